conv_seq_ctrl: RTL and testbench

- Sequencing controller for the 14x14 image, 3x3 kernel convolution datapath with 2x2 max-pool and 6x6 output.
- Counts the streamed pixel/weight inputs and issues weight-load strobes and window/pool alignment flags to the MAC datapath.
- Manages write and read addressing of the 36-entry result buffer, then drains it as one continuous out_valid burst of 36 words.
- Sits between the top-level input handshake and the datapath/result-buffer.

---
 rtl/conv_seq_ctrl_pkg.sv | 33 +++
 rtl/conv_seq_ctrl_if.sv | 46 ++++
 rtl/conv_seq_ctrl_flag_pipe.sv | 30 +++
 rtl/conv_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_conv_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_seq_ctrl_pkg.sv
// Shared constants and types for the convolution sequencing controller.
// Geometry is fixed: 14x14 image, 3x3 kernel, 2x2 max-pool, 6x6 pooled output.
// Contents: state enum, geometry and address-width localparams, and the pipelined flag bundle.
package conv_pkg;

  localparam int IMG_W   = 14;
  localparam int K       = 3;
  localparam int OUT_W   = (IMG_W - K + 1) / 2;
  localparam int OUT_NUM = OUT_W * OUT_W;
  localparam int TAPS    = K * K;
  localparam int CNT_W   = 16;

  localparam int PIX_CW = $clog2(IMG_W);
  localparam int ADDR_W = $clog2(OUT_NUM);
  localparam int TAP_W  = $clog2(TAPS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Flags that travel with a window pixel until its conv result appears.
  typedef struct packed {
    logic win;
    logic pool_done;
    logic row_first;
    logic col_first;
  } flag_t;

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Handshake and control bus between the input/datapath side and conv_seq_ctrl.
// master = the controller (drives strobes, addresses and flags); slave = datapath/top side.
// frame_cycles exists only when CONV_SEQ_PERF_CNT_EN is defined.
interface conv_seq_ctrl_if;
  import conv_pkg::*;

  logic              in_valid;
  logic              w_load_en;
  logic [TAP_W-1:0]  w_idx;
  logic              pix_en;
  logic              win_valid;
  logic              pool_row_first;
  logic              pool_col_first;
  logic              res_wr_en;
  logic [ADDR_W-1:0] res_wr_addr;
  logic              res_rd_en;
  logic [ADDR_W-1:0] res_rd_addr;
  logic              out_valid;
  logic              busy;
`ifdef CONV_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0]  frame_cycles;

  modport master (
    input  in_valid,
    output w_load_en, w_idx, pix_en, win_valid, pool_row_first, pool_col_first,
           res_wr_en, res_wr_addr, res_rd_en, res_rd_addr, out_valid, busy, frame_cycles
  );
  modport slave (
    output in_valid,
    input  w_load_en, w_idx, pix_en, win_valid, pool_row_first, pool_col_first,
           res_wr_en, res_wr_addr, res_rd_en, res_rd_addr, out_valid, busy, frame_cycles
  );
`else
  modport master (
    input  in_valid,
    output w_load_en, w_idx, pix_en, win_valid, pool_row_first, pool_col_first,
           res_wr_en, res_wr_addr, res_rd_en, res_rd_addr, out_valid, busy
  );
  modport slave (
    output in_valid,
    input  w_load_en, w_idx, pix_en, win_valid, pool_row_first, pool_col_first,
           res_wr_en, res_wr_addr, res_rd_en, res_rd_addr, out_valid, busy
  );
`endif

endinterface

// File: rtl/conv_seq_ctrl_flag_pipe.sv
// Delays the window/pool flag bundle by DEPTH cycles to line up with the datapath conv result.
// Latency: exactly DEPTH cycles; shifts every cycle, entries without win set are carried as all-zero.
// Backpressure: none; input stalls simply inject empty entries so alignment is kept.
// Ports: clk, rst_n (async active-low), din (flags of the current pixel), dout (flags DEPTH cycles ago).
module conv_flag_pipe
  import conv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  flag_t din,
  output flag_t dout
);

  flag_t sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      // Qualify on entry so downstream never sees stray pool flags.
      sr[0] <= din.win ? din : '0;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencing controller: counts streamed pixels/weights, flags windows and pool alignment, runs result buffer.
// Latency: pix/weight strobes same cycle as in_valid; write strobes PIPE_LAT later; 36-word burst after flush.
// Backpressure: in_valid=0 stalls the frame; in_valid outside IDLE/LOAD is ignored (never consumed).
// Ports: clk, rst_n (async active-low), bus (conv_seq_ctrl_if.master).
// Optional: CONV_SEQ_PERF_CNT_EN adds bus.frame_cycles (cycles from first beat through DONE, saturating).
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int PIPE_LAT = 4
) (
  input logic             clk,
  input logic             rst_n,
  conv_seq_ctrl_if.master bus
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_LOAD  = LOAD;
  localparam logic [2:0] ST_FLUSH = FLUSH;
  localparam logic [2:0] ST_OUT   = OUT;
  localparam logic [2:0] ST_DONE  = DONE;

  localparam logic [PIX_CW-1:0] LAST_RC   = PIX_CW'(IMG_W - 1);
  localparam logic [PIX_CW-1:0] WIN_START = PIX_CW'(K - 1);
  localparam logic [PIX_CW-1:0] TAP_NUM   = PIX_CW'(TAPS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_NUM - 1);
  localparam logic [ADDR_W-1:0] ADDR_NUM  = ADDR_W'(OUT_NUM);

  logic [2:0]        state, state_nxt;
  logic [PIX_CW-1:0] row, col;
  logic [ADDR_W-1:0] wr_cnt, rd_cnt;
  logic              out_vld_q;
  logic              accept, last_pix, win, wr_en, rd_en;
  flag_t             flag_in, flag_out;

  // Gated by rst_n so every output reads 0 for the whole reset period.
  assign accept   = bus.in_valid & rst_n & ((state == ST_IDLE) | (state == ST_LOAD));
  assign last_pix = (row == LAST_RC) & (col == LAST_RC);
  assign win      = accept & (row >= WIN_START) & (col >= WIN_START);

  // cr = row-2 and cc = col-2 have the same parity as row and col.
  assign flag_in = '{win: win, pool_done: row[0] & col[0], row_first: ~row[0], col_first: ~col[0]};

  conv_flag_pipe #(.DEPTH(PIPE_LAT)) u_flag_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (flag_in),
    .dout (flag_out)
  );

  assign wr_en = flag_out.win & flag_out.pool_done;
  assign rd_en = (state == ST_OUT);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_LOAD;
      ST_LOAD:  if (accept && last_pix) state_nxt = ST_FLUSH;
      ST_FLUSH: if (wr_en && (wr_cnt == LAST_ADDR)) state_nxt = ST_OUT;
      ST_OUT:   if (rd_cnt == LAST_ADDR) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_vld_q <= rd_en;
      // Row-major pixel position; wraps to (0,0) after the last pixel.
      if (accept) begin
        if (col == LAST_RC) begin
          col <= '0;
          row <= (row == LAST_RC) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // Pooled outputs finish in row-major order, so a plain counter is the address.
      if ((state == ST_IDLE) && accept) wr_cnt <= '0;
      else if (wr_en)                   wr_cnt <= wr_cnt + 1'b1;
      if (rd_en) rd_cnt <= (rd_cnt == LAST_ADDR) ? '0 : rd_cnt + 1'b1;
    end
  end

  assign bus.pix_en         = accept;
  assign bus.w_load_en      = accept & (row == '0) & (col < TAP_NUM);
  assign bus.w_idx          = bus.w_load_en ? TAP_W'(col) : '0;
  assign bus.win_valid      = win;
  assign bus.pool_row_first = flag_out.row_first;
  assign bus.pool_col_first = flag_out.col_first;
  assign bus.res_wr_en      = wr_en;
  assign bus.res_wr_addr    = wr_en ? wr_cnt : '0;
  assign bus.res_rd_en      = rd_en;
  assign bus.res_rd_addr    = rd_en ? rd_cnt : '0;
  assign bus.out_valid      = out_vld_q;
  assign bus.busy           = (state != ST_IDLE);

  a_no_extra_write: assert property (@(posedge clk) disable iff (!rst_n) wr_en |-> (wr_cnt < ADDR_NUM));

`ifdef CONV_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt, cnt_inc, fc_q;

  assign cnt_inc = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;

  // Starts at 1 so the accepting IDLE cycle is included in the total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      fc_q    <= '0;
    end else begin
      if ((state == ST_IDLE) && accept) cyc_cnt <= CNT_W'(1);
      else if (state != ST_IDLE)        cyc_cnt <= cnt_inc;
      if (state == ST_DONE) fc_q <= cnt_inc;
    end
  end

  assign bus.frame_cycles = fc_q;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: timeline reference model compared every cycle, plus literal pins.
// Covers reset, nominal frame, stalled frame, in_valid held high, mid-frame reset, random stalls.
// With CONV_SEQ_PERF_CNT_EN also checks frame_cycles over 200 back-to-back frames.
module tb_conv_seq_ctrl;

  localparam int P   = 4;
  localparam int IMG = 14;
  localparam int NPX = IMG * IMG;
  localparam int OW  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_seq_ctrl_if bus ();

  conv_seq_ctrl #(.PIPE_LAT(P)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int n_pass = 0, n_total = 0;
  int cur = 0;
  bit check_en = 0;

  // Reference model state: a frame is a timeline anchored at its first and last accepted beats.
  int frame_on = 0, beats = 0, m_t0 = 0, m_last = -1, frames_done = 0;
  int ev_f [int];
  int ev_a [int];
  int exp_pix, exp_wl, exp_widx, exp_win, exp_rowf, exp_colf, exp_wr, exp_waddr;
  int exp_rd, exp_raddr, exp_ov, exp_busy, exp_fc;

  // Observations of the DUT used for the literal checks.
  int obs_base, obs_first_win, obs_ov_first, obs_ov_last, obs_ov_cnt;
  int obs_wr, obs_wl, obs_pix, obs_idle, obs_seen_busy;

  task automatic chk(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cur, act, expv);
  endtask

  task automatic model_reset();
    frame_on = 0; beats = 0; m_last = -1; exp_fc = 0;
    ev_f.delete(); ev_a.delete();
  endtask

  task automatic model_step(input bit iv);
    int b, r, c, cr, cc;
    bit acc;
    exp_pix = 0; exp_wl = 0; exp_widx = 0; exp_win = 0; exp_rowf = 0; exp_colf = 0;
    exp_wr = 0; exp_waddr = 0; exp_rd = 0; exp_raddr = 0; exp_ov = 0;
    // Frame returns to idle 38+P cycles after its last pixel.
    if (frame_on != 0 && m_last >= 0 && cur == m_last + 38 + P) begin
      frame_on = 0;
      exp_fc = cur - m_t0;
      frames_done++;
    end
    exp_busy = frame_on;
    acc = iv && (frame_on == 0 || beats < NPX);
    if (acc) begin
      if (frame_on == 0) begin
        frame_on = 1; beats = 0; m_t0 = cur; m_last = -1;
      end
      b = beats; r = b / IMG; c = b % IMG;
      exp_pix = 1;
      if (b < 9) begin exp_wl = 1; exp_widx = b; end
      if (r >= 2 && c >= 2) begin
        exp_win = 1; cr = r - 2; cc = c - 2;
        ev_f[cur+P] = ((cr % 2 == 1 && cc % 2 == 1) ? 4 : 0) + ((cr % 2 == 0) ? 2 : 0) + ((cc % 2 == 0) ? 1 : 0);
        ev_a[cur+P] = (cr / 2) * OW + cc / 2;
      end
      beats++;
      if (beats == NPX) m_last = cur;
    end
    if (ev_f.exists(cur)) begin
      exp_wr    = (ev_f[cur] >> 2) & 1;
      exp_rowf  = (ev_f[cur] >> 1) & 1;
      exp_colf  = ev_f[cur] & 1;
      exp_waddr = ev_a[cur];
      ev_f.delete(cur); ev_a.delete(cur);
    end
    if (frame_on != 0 && m_last >= 0) begin
      if (cur >= m_last + 1 + P && cur <= m_last + 36 + P) begin
        exp_rd = 1; exp_raddr = cur - (m_last + 1 + P);
      end
      if (cur >= m_last + 2 + P && cur <= m_last + 37 + P) exp_ov = 1;
    end
  endtask

  // The single compare process: every checked cycle, DUT against model, away from the clock edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("pix_en", int'(bus.pix_en), exp_pix);
      chk("w_load_en", int'(bus.w_load_en), exp_wl);
      chk("w_idx", int'(bus.w_idx), exp_widx);
      chk("win_valid", int'(bus.win_valid), exp_win);
      chk("pool_row_first", int'(bus.pool_row_first), exp_rowf);
      chk("pool_col_first", int'(bus.pool_col_first), exp_colf);
      chk("res_wr_en", int'(bus.res_wr_en), exp_wr);
      if (exp_wr != 0) chk("res_wr_addr", int'(bus.res_wr_addr), exp_waddr);
      chk("res_rd_en", int'(bus.res_rd_en), exp_rd);
      if (exp_rd != 0) chk("res_rd_addr", int'(bus.res_rd_addr), exp_raddr);
      chk("out_valid", int'(bus.out_valid), exp_ov);
      chk("busy", int'(bus.busy), exp_busy);
`ifdef CONV_SEQ_PERF_CNT_EN
      chk("frame_cycles", int'(bus.frame_cycles), exp_fc);
`endif
      if (bus.win_valid && obs_first_win < 0) obs_first_win = cur - obs_base;
      if (bus.out_valid) begin
        if (obs_ov_first < 0) obs_ov_first = cur - obs_base;
        obs_ov_last = cur - obs_base;
        obs_ov_cnt++;
      end
      if (bus.res_wr_en) obs_wr++;
      if (bus.w_load_en) obs_wl++;
      if (bus.pix_en) obs_pix++;
      if (bus.busy) obs_seen_busy = 1;
      else if (obs_seen_busy != 0 && obs_idle < 0) obs_idle = cur - obs_base;
    end
  end

  task automatic clear_obs();
    obs_base = cur + 1;
    obs_first_win = -1; obs_ov_first = -1; obs_ov_last = -1; obs_ov_cnt = 0;
    obs_wr = 0; obs_wl = 0; obs_pix = 0; obs_idle = -1; obs_seen_busy = 0;
  endtask

  task automatic cyc_step(input bit iv);
    @(posedge clk);
    #1;
    cur = cur + 1;
    bus.in_valid = iv;
    model_step(iv);
    check_en = 1;
  endtask

  task automatic run(input bit iv, input int n);
    for (int i = 0; i < n; i++) cyc_step(iv);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pix_en"}, int'(bus.pix_en), 0);
    chk({tag, "_w_load_en"}, int'(bus.w_load_en), 0);
    chk({tag, "_w_idx"}, int'(bus.w_idx), 0);
    chk({tag, "_win_valid"}, int'(bus.win_valid), 0);
    chk({tag, "_pool_row_first"}, int'(bus.pool_row_first), 0);
    chk({tag, "_pool_col_first"}, int'(bus.pool_col_first), 0);
    chk({tag, "_res_wr_en"}, int'(bus.res_wr_en), 0);
    chk({tag, "_res_wr_addr"}, int'(bus.res_wr_addr), 0);
    chk({tag, "_res_rd_en"}, int'(bus.res_rd_en), 0);
    chk({tag, "_res_rd_addr"}, int'(bus.res_rd_addr), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
`ifdef CONV_SEQ_PERF_CNT_EN
    chk({tag, "_frame_cycles"}, int'(bus.frame_cycles), 0);
`endif
  endtask

  // Asserts reset mid-cycle (in_valid left as is) and checks outputs drop at once.
  task automatic reset_pulse(input string tag);
    #2;
    check_en = 0;
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    repeat (3) @(negedge clk);
    model_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    bus.in_valid = 1'b0;
    model_reset();

    // Reset held for 10 cycles.
    repeat (10) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 5);

    // Nominal frame.
    clear_obs();
    run(1'b1, NPX);
    run(1'b0, 60);
    chk("nom_first_win", obs_first_win, 30);
    chk("nom_wl_cnt", obs_wl, 9);
    chk("nom_wr_cnt", obs_wr, 36);
    chk("nom_ov_first", obs_ov_first, 201);
    chk("nom_ov_last", obs_ov_last, 236);
    chk("nom_ov_cnt", obs_ov_cnt, 36);
    chk("nom_idle", obs_idle, 237);
    chk("model_last_pixel", m_last - obs_base, 195);
`ifdef CONV_SEQ_PERF_CNT_EN
    chk("nom_frame_cycles", int'(bus.frame_cycles), 237);
`endif

    // Stall of 5 cycles after beat 100.
    clear_obs();
    run(1'b1, 101);
    run(1'b0, 5);
    run(1'b1, NPX - 101);
    run(1'b0, 60);
    chk("stall_ov_first", obs_ov_first, 206);
    chk("stall_ov_last", obs_ov_last, 241);
    chk("stall_ov_cnt", obs_ov_cnt, 36);
    chk("stall_wr_cnt", obs_wr, 36);
    chk("stall_idle", obs_idle, 242);

    // in_valid held high through FLUSH/OUT/DONE: exactly two frames in 474 cycles.
    clear_obs();
    run(1'b1, 474);
    run(1'b0, 5);
    chk("hold_pix_cnt", obs_pix, 2 * NPX);
    chk("hold_ov_cnt", obs_ov_cnt, 72);
    chk("hold_wr_cnt", obs_wr, 72);

    // Mid-frame reset at beat 150, then a fresh frame.
    run(1'b1, 151);
    reset_pulse("midrst");
    clear_obs();
    run(1'b1, NPX);
    run(1'b0, 60);
    chk("midrst_ov_first", obs_ov_first, 201);
    chk("midrst_ov_cnt", obs_ov_cnt, 36);
    chk("midrst_wr_cnt", obs_wr, 36);

    // Random stalls everywhere, six complete frames.
    clear_obs();
    frames_done = 0;
    guard = 0;
    while (frames_done < 6 && guard < 6000) begin
      cyc_step($urandom_range(0, 9) < 7);
      guard++;
    end
    chk("rand_frames_done", frames_done, 6);
    chk("rand_ov_cnt", obs_ov_cnt, 216);
    chk("rand_wr_cnt", obs_wr, 216);
    reset_pulse("randrst");
    run(1'b0, 3);

`ifdef CONV_SEQ_PERF_CNT_EN
    // 200 back-to-back frames; frame_cycles must read 237 after each.
    clear_obs();
    run(1'b1, 200 * 237);
    run(1'b0, 2);
    chk("perf_ov_cnt", obs_ov_cnt, 200 * 36);
    chk("perf_frame_cycles", int'(bus.frame_cycles), 237);
`endif

    @(posedge clk);
    check_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
